pipe_stage_reg: RTL

Generic parametrised inter-stage pipeline register for the MIPS pipeline, successor to the fixed per-stage latch blocks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle with a valid/ready handshake.
- Uses a 2-entry skid buffer so a downstream stall never combinationally reaches upstream.
- Supports synchronous flush that turns in-flight entries into bubbles, as needed for branch/jump squash.

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]    NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              accept;
    logic              pop;

    // in_ready is purely registered so downstream stalls never reach upstream combinationally
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

    assign accept = in_valid & ~skid_valid_q;
    assign pop    = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = NOP_CTRL;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
            end else begin
                skid_valid_d = 1'b0;
                if (accept) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                    main_ctrl_d  = in_ctrl;
                end else begin
                    main_valid_d = 1'b0;
                    main_ctrl_d  = NOP_CTRL;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= NOP_CTRL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= NOP_CTRL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush && (main_valid_q || skid_valid_q) && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule
